// File: rtl/arbitro_rr8_pkg.sv
// Shared definitions for the eight-source round-robin arbiter.
// Contents: FSM state encoding, pointer/data/counter widths, the number of
// sources and the default MAX_WAIT value.
package arb_pkg;

    localparam int N_SRC        = 8;
    localparam int PTR_W        = 3;
    localparam int DATA_W       = 5;
    localparam int CNT_W        = 8;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/arbitro_rr8_if.sv
// Bus bundle between the arbiter and its environment.
// Signals:
//   req        8  per-source request
//   A0..A7     5  source data words
//   out_ready  1  downstream accepts out_data this cycle
//   SEL0..SEL2 1  mux select, {SEL0,SEL1,SEL2} = source index (SEL0 is MSB)
//   gnt        8  one-hot capture pulse
//   out_valid  1  out_data/out_src hold a pending transfer
//   out_data   5  captured word
//   out_src    3  index of the captured source
//   drop       1  pending transfer discarded after MAX_WAIT
// Modports: master = sources + downstream, slave = arbiter.
interface arbitro_rr8_if import arb_pkg::*; ();

    logic [N_SRC-1:0] req;
    data_t            A0, A1, A2, A3, A4, A5, A6, A7;
    logic             out_ready;
    logic             SEL0, SEL1, SEL2;
    logic [N_SRC-1:0] gnt;
    logic             out_valid;
    data_t            out_data;
    ptr_t             out_src;
    logic             drop;

    modport master (
        output req, A0, A1, A2, A3, A4, A5, A6, A7, out_ready,
        input  SEL0, SEL1, SEL2, gnt, out_valid, out_data, out_src, drop
    );

    modport slave (
        input  req, A0, A1, A2, A3, A4, A5, A6, A7, out_ready,
        output SEL0, SEL1, SEL2, gnt, out_valid, out_data, out_src, drop
    );

endinterface

// File: rtl/mux8_1.sv
// Eight-to-one word multiplexer.
// Ports: sel_i (3) selects one of d0_i..d7_i (W each) onto y_o (W).
module mux8_1 #(
    parameter int W = 5
) (
    input  logic [2:0]   sel_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  logic [W-1:0] d4_i,
    input  logic [W-1:0] d5_i,
    input  logic [W-1:0] d6_i,
    input  logic [W-1:0] d7_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives y_o; no latch.
        y_o = d0_i;
        case (sel_i)
            3'd1:    y_o = d1_i;
            3'd2:    y_o = d2_i;
            3'd3:    y_o = d3_i;
            3'd4:    y_o = d4_i;
            3'd5:    y_o = d5_i;
            3'd6:    y_o = d6_i;
            3'd7:    y_o = d7_i;
            default: y_o = d0_i;
        endcase
    end

endmodule

// File: rtl/rr_prio8.sv
// Round-robin priority search over eight requests.
// Ports: req_i (8) requests, ptr_i (3) highest-priority index;
//        w_o (3) first set request from ptr_i upward with wrap 7->0,
//        any_o (1) at least one request is set.
module rr_prio8 import arb_pkg::*; (
    input  logic [N_SRC-1:0] req_i,
    input  ptr_t             ptr_i,
    output ptr_t             w_o,
    output logic             any_o
);

    always_comb begin
        ptr_t idx;
        idx   = '0;
        w_o   = ptr_i;
        any_o = 1'b0;
        // Walk from the lowest priority offset to the highest so the last
        // hit, i.e. the one closest to ptr_i, is the one that sticks.
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = ptr_i + ptr_t'(k);
            if (req_i[idx]) begin
                w_o   = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr8.sv
// Eight-source round-robin arbiter with a one-word output holding register.
// A winning source's word is captured into out_data and held until the
// downstream accepts it (out_ready) or MAX_WAIT unaccepted cycles elapse,
// in which case it is dropped. Acceptance with pending requests re-arbitrates
// on the same edge, so back-to-back transfers have no bubble.
// Ports: clk, reset (synchronous, active-high), bus (arbitro_rr8_if.slave).
module arbitro_rr8 import arb_pkg::*; #(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    arbitro_rr8_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    state_e           state_q;
    ptr_t             ptr_q, ptr_d;
    ptr_t             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q;
    data_t            out_data_q;
    ptr_t             out_src_q;
    logic [N_SRC-1:0] gnt_q;
    logic             drop_q;

    ptr_t  w;
    logic  any;
    logic  arb_en;
    logic  capture;
    logic  sel0, sel1, sel2;
    data_t mux_y;

    rr_prio8 u_prio (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .w_o   (w),
        .any_o (any)
    );

    // Arbitration runs when idle, or while holding only in the accept cycle.
    assign arb_en  = (state_q == IDLE) || bus.out_ready;
    assign capture = arb_en && any;

    // SEL follows the winner in a capture cycle and otherwise keeps the last
    // winner, so the mux output is stable while nothing is being granted.
    assign sel_d = capture ? w : sel_q;
    assign ptr_d = w + ptr_t'(1);
    assign cnt_d = cnt_q + CNT_W'(1);

    assign sel0 = sel_d[2];
    assign sel1 = sel_d[1];
    assign sel2 = sel_d[0];

    mux8_1 #(.W(DATA_W)) u_mux (
        .sel_i ({sel0, sel1, sel2}),
        .d0_i  (bus.A0),
        .d1_i  (bus.A1),
        .d2_i  (bus.A2),
        .d3_i  (bus.A3),
        .d4_i  (bus.A4),
        .d5_i  (bus.A5),
        .d6_i  (bus.A6),
        .d7_i  (bus.A7),
        .y_o   (mux_y)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            gnt_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            gnt_q  <= '0;
            drop_q <= 1'b0;
            if (capture) begin
                out_data_q  <= mux_y;
                out_src_q   <= w;
                out_valid_q <= 1'b1;
                gnt_q       <= N_SRC'(1) << w;
                ptr_q       <= ptr_d;
                sel_q       <= w;
                cnt_q       <= '0;
                state_q     <= HOLD;
            end else if (state_q == HOLD) begin
                if (bus.out_ready) begin
                    // Accepted with nothing new to capture.
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end else begin
                    cnt_q <= cnt_d;
                    if (cnt_d == MAX_WAIT_C) begin
                        // Timed out: discard the word, pointer stays put.
                        out_valid_q <= 1'b0;
                        drop_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.SEL0      = sel0;
    assign bus.SEL1      = sel1;
    assign bus.SEL2      = sel2;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_arbitro_rr8.sv
// Directed self-checking bench for arbitro_rr8 (MAX_WAIT = 3).
module tb_arbitro_rr8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    arbitro_rr8_if bus ();

    arbitro_rr8 #(.MAX_WAIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2:0] sel_obs;
    assign sel_obs = {bus.SEL0, bus.SEL1, bus.SEL2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (bus.gnt !== 8'h00) begin $display("FAIL reset_gnt: got %h want 00", bus.gnt); n_fail++; end
        n_chk++; if (bus.drop !== 1'b0) begin $display("FAIL reset_drop: got %b want 0", bus.drop); n_fail++; end
        n_chk++; if (bus.out_data !== 5'h00) begin $display("FAIL reset_data: got %h want 00", bus.out_data); n_fail++; end
        n_chk++; if (bus.out_src !== 3'd0) begin $display("FAIL reset_src: got %0d want 0", bus.out_src); n_fail++; end
        n_chk++; if (sel_obs !== 3'd0) begin $display("FAIL reset_sel: got %0d want 0", sel_obs); n_fail++; end
        n_chk++; if (dut.ptr_q !== 3'd0) begin $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); n_fail++; end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bus.req = 8'h01;
        bus.A0 = 5'h15;
        bus.out_ready = 1'b1;
        #1;
        n_chk++; if (sel_obs !== 3'd0) begin $display("FAIL single_sel: got %0d want 0", sel_obs); n_fail++; end
        tick();
        n_chk++; if (bus.gnt !== 8'h01) begin $display("FAIL single_gnt: got %h want 01", bus.gnt); n_fail++; end
        n_chk++; if (bus.out_valid !== 1'b1) begin $display("FAIL single_valid: got %b want 1", bus.out_valid); n_fail++; end
        n_chk++; if (bus.out_data !== 5'h15) begin $display("FAIL single_data: got %h want 15", bus.out_data); n_fail++; end
        n_chk++; if (bus.out_src !== 3'd0) begin $display("FAIL single_src: got %0d want 0", bus.out_src); n_fail++; end
        n_chk++; if (dut.ptr_q !== 3'd1) begin $display("FAIL single_ptr: got %0d want 1", dut.ptr_q); n_fail++; end
        bus.req = 8'h00;
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL single_accept_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (bus.gnt !== 8'h00) begin $display("FAIL single_gnt_pulse: got %h want 00", bus.gnt); n_fail++; end
    endtask

    task automatic test_back_to_back();
        int exp_src [4] = '{0, 7, 0, 7};
        logic [7:0] exp_gnt;
        logic [4:0] exp_data;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 8'b1000_0001;
        bus.A0 = 5'h01;
        bus.A7 = 5'h17;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_gnt  = 8'h01 << exp_src[i];
            exp_data = (exp_src[i] == 0) ? 5'h01 : 5'h17;
            n_chk++; if (bus.gnt !== exp_gnt) begin $display("FAIL b2b_gnt[%0d]: got %h want %h", i, bus.gnt, exp_gnt); n_fail++; end
            n_chk++; if (bus.out_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid); n_fail++; end
            n_chk++; if (bus.out_src !== 3'(exp_src[i])) begin $display("FAIL b2b_src[%0d]: got %0d want %0d", i, bus.out_src, exp_src[i]); n_fail++; end
            n_chk++; if (bus.out_data !== exp_data) begin $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.out_data, exp_data); n_fail++; end
        end
        bus.req = 8'h00;
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL b2b_end_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (dut.ptr_q !== 3'd0) begin $display("FAIL b2b_end_ptr: got %0d want 0", dut.ptr_q); n_fail++; end
    endtask

    task automatic test_wrap();
        // Grant source 5 once to move the pointer to 6.
        bus.req = 8'h20;
        bus.A5 = 5'h05;
        bus.out_ready = 1'b1;
        tick();
        n_chk++; if (dut.ptr_q !== 3'd6) begin $display("FAIL wrap_setup_ptr: got %0d want 6", dut.ptr_q); n_fail++; end
        bus.req = 8'h00;
        tick();
        bus.req = 8'b0000_0110;
        bus.A1 = 5'h11;
        bus.A2 = 5'h12;
        #1;
        n_chk++; if (sel_obs !== 3'd1) begin $display("FAIL wrap_sel1: got %0d want 1", sel_obs); n_fail++; end
        tick();
        n_chk++; if (bus.gnt !== 8'h02) begin $display("FAIL wrap_gnt1: got %h want 02", bus.gnt); n_fail++; end
        n_chk++; if (bus.out_data !== 5'h11) begin $display("FAIL wrap_data1: got %h want 11", bus.out_data); n_fail++; end
        bus.req = 8'b0000_0100;
        #1;
        n_chk++; if (sel_obs !== 3'd2) begin $display("FAIL wrap_sel2: got %0d want 2", sel_obs); n_fail++; end
        tick();
        n_chk++; if (bus.gnt !== 8'h04) begin $display("FAIL wrap_gnt2: got %h want 04", bus.gnt); n_fail++; end
        n_chk++; if (bus.out_src !== 3'd2) begin $display("FAIL wrap_src2: got %0d want 2", bus.out_src); n_fail++; end
        bus.req = 8'h00;
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL wrap_end_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (sel_obs !== 3'd2) begin $display("FAIL wrap_sel_hold: got %0d want 2", sel_obs); n_fail++; end
    endtask

    task automatic test_drop();
        // Pointer is 3 here; source 3 wins and is never accepted.
        bus.req = 8'b0000_1000;
        bus.A3 = 5'h03;
        bus.out_ready = 1'b0;
        tick();
        n_chk++; if (bus.gnt !== 8'h08) begin $display("FAIL drop_gnt: got %h want 08", bus.gnt); n_fail++; end
        bus.req = 8'h00;
        bus.A3 = 5'h1f;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_chk++; if (bus.out_valid !== 1'b1) begin $display("FAIL drop_hold_valid[%0d]: got %b want 1", i, bus.out_valid); n_fail++; end
            n_chk++; if (bus.out_data !== 5'h03) begin $display("FAIL drop_hold_data[%0d]: got %h want 03", i, bus.out_data); n_fail++; end
            n_chk++; if (bus.drop !== 1'b0) begin $display("FAIL drop_early[%0d]: got %b want 0", i, bus.drop); n_fail++; end
        end
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL drop_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (bus.drop !== 1'b1) begin $display("FAIL drop_pulse: got %b want 1", bus.drop); n_fail++; end
        n_chk++; if (dut.ptr_q !== 3'd4) begin $display("FAIL drop_ptr: got %0d want 4", dut.ptr_q); n_fail++; end
        tick();
        n_chk++; if (bus.drop !== 1'b0) begin $display("FAIL drop_pulse_len: got %b want 0", bus.drop); n_fail++; end
    endtask

    task automatic test_accept_at_limit();
        // Pointer is 4; accept arrives in the cycle that would hit MAX_WAIT.
        bus.req = 8'b0001_0000;
        bus.A4 = 5'h14;
        bus.out_ready = 1'b0;
        tick();
        n_chk++; if (bus.gnt !== 8'h10) begin $display("FAIL limit_gnt: got %h want 10", bus.gnt); n_fail++; end
        bus.req = 8'h00;
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL limit_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (bus.drop !== 1'b0) begin $display("FAIL limit_drop: got %b want 0", bus.drop); n_fail++; end
        tick();
        n_chk++; if (bus.drop !== 1'b0) begin $display("FAIL limit_drop_late: got %b want 0", bus.drop); n_fail++; end
    endtask

    task automatic test_reset_in_hold();
        // Pointer is 5; source 6 is captured, then reset hits while holding.
        bus.req = 8'h40;
        bus.A6 = 5'h16;
        bus.out_ready = 1'b0;
        tick();
        n_chk++; if (bus.out_src !== 3'd6) begin $display("FAIL rst_hold_src: got %0d want 6", bus.out_src); n_fail++; end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) begin $display("FAIL rst_hold_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_chk++; if (bus.gnt !== 8'h00) begin $display("FAIL rst_hold_gnt: got %h want 00", bus.gnt); n_fail++; end
        n_chk++; if (bus.drop !== 1'b0) begin $display("FAIL rst_hold_drop: got %b want 0", bus.drop); n_fail++; end
        n_chk++; if (bus.out_data !== 5'h00) begin $display("FAIL rst_hold_data: got %h want 00", bus.out_data); n_fail++; end
        n_chk++; if (bus.out_src !== 3'd0) begin $display("FAIL rst_hold_src0: got %0d want 0", bus.out_src); n_fail++; end
        n_chk++; if (dut.ptr_q !== 3'd0) begin $display("FAIL rst_hold_ptr: got %0d want 0", dut.ptr_q); n_fail++; end
        bus.req = 8'h00;
        #1;
        n_chk++; if (sel_obs !== 3'd0) begin $display("FAIL rst_hold_sel: got %0d want 0", sel_obs); n_fail++; end
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        bus.A0 = '0; bus.A1 = '0; bus.A2 = '0; bus.A3 = '0;
        bus.A4 = '0; bus.A5 = '0; bus.A6 = '0; bus.A7 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_drop();
        test_accept_at_limit();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_rr8.md
ARBITRO_RR8 -- requirements
Module: arbitro_rr8

Interface
REQ-001 Parameter MAX_WAIT, default 15: cycles out_valid may stay unaccepted before the transfer is dropped; legal 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request per source; bit i requests transfer of Ai.
REQ-005 A0..A7  input  5 each  source data words.
REQ-006 out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 SEL0, SEL1, SEL2  output  1 each  mux select; source index = {SEL0,SEL1,SEL2}, SEL0 is MSB.
REQ-008 gnt  output  8  one-hot, one-cycle pulse: source i's word has been captured.
REQ-009 out_valid  output  1  out_data/out_src hold a pending transfer.
REQ-010 out_data  output  5  captured word of the granted source.
REQ-011 out_src  output  3  index of the source that produced out_data.
REQ-012 drop  output  1  one-cycle pulse: pending transfer discarded after MAX_WAIT.

Function
REQ-013 States SHALL be IDLE and HOLD; reset state IDLE.
REQ-014 Round-robin pointer ptr (3 bits) SHALL name the highest-priority source; priority descends ptr, ptr+1, ... mod 8.
REQ-015 Arbitration is enabled in IDLE, and in HOLD in the cycle out_ready=1 (accept cycle).
REQ-016 When enabled and req!=0, winner w = first set req bit searching from ptr with wrap 7->0; SEL SHALL equal w combinationally that cycle.
REQ-017 At the edge ending that cycle: out_data <= A[w], out_src <= w, out_valid <= 1, gnt[w] pulses 1 for the following cycle, ptr <= w+1 mod 8, state HOLD.
REQ-018 Latency: req rising in IDLE -> out_valid and gnt one cycle later.
REQ-019 In HOLD, out_data/out_src SHALL remain stable until accepted or dropped; arbitration disabled unless accept cycle.
REQ-020 Accept with req!=0: new word captured same edge (back-to-back, no bubble); out_valid stays 1.
REQ-021 Accept with req==0: out_valid <= 0, state IDLE.
REQ-022 When enabled and req==0: SEL SHALL hold its last value; no state change except REQ-021.
REQ-023 Wait counter (8 bits) SHALL clear on every capture, increment each HOLD cycle with out_ready=0.
REQ-024 When counter reaches MAX_WAIT with out_ready=0: out_valid <= 0, drop pulses next cycle, state IDLE; ptr unchanged.
REQ-025 out_ready=1 in the same cycle the counter reaches MAX_WAIT SHALL count as accept; no drop.
REQ-026 Requester SHALL hold req until its gnt pulse; req bits changing while not enabled have no effect.
REQ-027 A source whose req stays high after its gnt is treated as a new request (subject to round-robin).

Reset
REQ-028 reset SHALL dominate all other inputs in the cycle it is sampled.
REQ-029 Reset values: state IDLE, ptr 0, counter 0, out_valid 0, out_data 0, out_src 0, gnt 0, drop 0, SEL 000.
REQ-030 Reset during HOLD SHALL discard the pending word without a drop pulse.

Structure
REQ-031 State encoding, pointer width (3), data width (5) and MAX_WAIT default SHALL live in shared package arb_pkg.
REQ-032 Source selection SHALL reuse existing module mux8_1 driven by SEL0..SEL2; the round-robin search SHALL be sub-module rr_prio8 (inputs req, ptr; outputs w, any).

Verification
REQ-033 Reset, then req=0000_0001, A0=5'h15, out_ready=1 -> next cycle gnt=0000_0001, out_data=15h, out_src=0, ptr=1.
REQ-034 ptr=0, req=1000_0001 held, out_ready=1 -> grants alternate 0,7,0,7 each cycle with out_valid continuously 1.
REQ-035 ptr=6, req=0000_0110 -> first grant source 1 (wrap), then source 2.
REQ-036 MAX_WAIT=3, one grant, out_ready=0 -> out_valid falls after 3 HOLD cycles, drop=1 for one cycle, ptr unchanged.
REQ-037 Counter at 2 of 3, out_ready=1 same cycle as third count -> accepted, no drop.
REQ-038 reset asserted in HOLD with out_valid=1 -> next cycle all outputs at REQ-029 values, drop=0.
